dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit directly upstream of the data memory; the only block that drives the memory's E/WE/Addr/DI pins.
- Accepts one request at a time from the execute stage: LOAD, STORE, INC (memory +1) or DEC (memory −1).
- Sequences the memory access and returns a response through a valid/ready handshake.
- Optionally zero-sweeps all memory locations after reset.

Parameters:
- ADDR_W, 4, memory address width; depth = 2**ADDR_W.
- DATA_W, 8, data width.
- CLEAR_ON_RESET, 1, 1 = zero-sweep memory after reset; 0 = go straight to IDLE.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  2  00 LOAD, 01 STORE, 10 INC, 11 DEC.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  store data; ignored for other ops.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_W  LOAD: read value; STORE: written value; INC/DEC: new value.
- rsp_zero  out  1  rsp_data == 0.
- busy  out  1  state != IDLE.
- mem_e  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_di  out  DATA_W  memory write data.
- mem_do  in  DATA_W  memory read data; combinational from mem_addr while mem_e=1, else 0.

Behaviour:
- States: CLEAR, IDLE, READ, WRITE, RESP.
- Reset: state=CLEAR (IDLE if CLEAR_ON_RESET=0); clear counter=0; op/addr/wdata/rdata registers=0.
- Output values at reset: rsp_valid=0, rsp_data=0, rsp_zero=1, mem_e=0, mem_we=0, mem_addr=0, mem_di=0.
- req_ready=1 only in IDLE.
- Memory outputs are decoded from state and registers only; never from req_* inputs directly.
- CLEAR:
  - Each cycle drives mem_e=1, mem_we=1, mem_addr=counter, mem_di=0; counter increments.
  - After address 2**ADDR_W−1 is written → IDLE. Duration is exactly 2**ADDR_W cycles.
  - Requests are ignored (req_ready=0).
- IDLE:
  - mem_e=0, mem_we=0.
  - On req_valid && req_ready, latch op/addr/wdata.
  - STORE → WRITE; LOAD/INC/DEC → READ.
- READ:
  - Drives mem_e=1, mem_we=0, mem_addr=addr.
  - Captures mem_do into rdata at the clock edge.
  - LOAD → RESP; INC/DEC → WRITE.
- WRITE:
  - Drives mem_e=1, mem_we=1, mem_addr=addr.
  - mem_di = wdata (STORE), rdata+1 (INC) or rdata−1 (DEC).
  - Arithmetic is modulo 2**DATA_W: 8'hFF+1=8'h00, 8'h00−1=8'hFF.
  - The value written is registered as the result → RESP.
- RESP:
  - rsp_valid=1; rsp_data/rsp_zero are registered and stable while rsp_valid && !rsp_ready.
  - On rsp_ready → IDLE; rsp_valid drops the next cycle.
  - A new request can be accepted no earlier than the cycle after the RESP handshake.
- Latency, with acceptance in cycle N and rsp_ready held high:
  - LOAD, STORE: rsp_valid in N+2.
  - INC, DEC: rsp_valid in N+3.
- Exactly one write pulse per STORE/INC/DEC; no write for LOAD.
- Back-to-back requests on the same address see the prior result; no forwarding is needed because the unit is single-outstanding.
- Reset asserted mid-operation:
  - Aborts immediately; any pending response is discarded.
  - The memory write in the reset cycle is undefined.
  - CLEAR restarts from address 0.
- rsp_ready high outside RESP has no effect.
- req_* inputs are don't-care when not in IDLE.

Decomposition:
- Package dmem_lsu_pkg:
  - op encoding constants OP_LOAD/OP_STORE/OP_INC/OP_DEC.
  - state enum.
  - default ADDR_W/DATA_W constants.
- No sub-module: FSM, clear counter and ±1 datapath fit in one module.

Test Plan:
- Reset, then hold req_valid=1 → req_ready=0 for 16 cycles with mem_we=1, mem_addr sweeping 0..15, mem_di=0; then req_ready=1; a LOAD of any address returns 8'h00, rsp_zero=1.
- STORE addr 3 data 8'hA5 → one write cycle (mem_addr=3, mem_di=8'hA5), rsp_valid at N+2; then LOAD 3 → rsp_data=8'hA5 at N+2, mem_we never high.
- STORE 7=8'hFF, INC 7 → READ then WRITE mem_di=8'h00, rsp_data=8'h00, rsp_zero=1 at N+3; DEC 7 → rsp_data=8'hFF.
- LOAD with rsp_ready=0 for 5 cycles → rsp_valid and rsp_data held stable, req_ready=0, mem_e=0 throughout; rsp_ready=1 → IDLE next cycle.
- Reset asserted in WRITE of an INC → rsp_valid=0 immediately, state=CLEAR, sweep restarts at address 0, memory reads all zero afterwards.
- CLEAR_ON_RESET=0 → req_ready=1 in the first cycle after reset; mem_e stays 0 until the first request.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared op encodings, state enum and default widths for dmem_lsu
package dmem_lsu_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_DEC   = 2'b11;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - single-outstanding load/store/inc/dec unit driving the data memory pins
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              busy,
    output logic              mem_e,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] wr_value;
    logic              mem_e_raw;
    logic              mem_we_raw;

    always_comb begin
        case (op_q)
            OP_INC:  wr_value = rdata_q + DATA_W'(1);
            OP_DEC:  wr_value = rdata_q - DATA_W'(1);
            default: wr_value = wdata_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = ST_IDLE;
            ST_IDLE:  if (req_valid) state_nxt = (req_op == OP_STORE) ? ST_WRITE : ST_READ;
            ST_READ:  state_nxt = (op_q == OP_LOAD) ? ST_RESP : ST_WRITE;
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Memory pins come only from state and registers; reset forces the enables low.
    always_comb begin
        mem_e_raw  = 1'b0;
        mem_we_raw = 1'b0;
        mem_addr   = addr_q;
        mem_di     = '0;
        case (state)
            ST_CLEAR: begin
                mem_e_raw  = 1'b1;
                mem_we_raw = 1'b1;
                mem_addr   = clr_cnt;
            end
            ST_READ: mem_e_raw = 1'b1;
            ST_WRITE: begin
                mem_e_raw  = 1'b1;
                mem_we_raw = 1'b1;
                mem_di     = wr_value;
            end
            default: ;
        endcase
    end

    assign mem_e     = mem_e_raw & ~rst;
    assign mem_we    = mem_we_raw & ~rst;
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign rsp_data  = result_q;
    assign rsp_zero  = (result_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt  <= '0;
            op_q     <= OP_LOAD;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_CLEAR: clr_cnt <= clr_cnt + ADDR_W'(1);
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                ST_READ: begin
                    rdata_q <= mem_do;
                    if (op_q == OP_LOAD) result_q <= mem_do;
                end
                ST_WRITE: result_q <= wr_value;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu with a behavioural memory
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = OP_LOAD;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       busy;
    logic       mem_e, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_di, mem_do;

    logic       req_ready2, rsp_valid2, rsp_zero2, busy2, mem_e2, mem_we2;
    logic [7:0] rsp_data2, mem_di2;
    logic [3:0] mem_addr2;

    logic [7:0] mem [16];
    int         wr_count = 0;
    logic [3:0] last_wa = '0;
    logic [7:0] last_wd = '0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(4), .DATA_W(8), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .busy(busy), .mem_e(mem_e), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
    );

    dmem_lsu #(.ADDR_W(4), .DATA_W(8), .CLEAR_ON_RESET(1'b0)) u_dut_nc (
        .clk(clk), .rst(rst), .req_valid(1'b0), .req_ready(req_ready2),
        .req_op(2'b00), .req_addr(4'h0), .req_wdata(8'h00),
        .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_data(rsp_data2),
        .rsp_zero(rsp_zero2), .busy(busy2), .mem_e(mem_e2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_di(mem_di2), .mem_do(8'h00)
    );

    // Memory starts with garbage so the clear sweep is actually observable.
    initial for (int i = 0; i < 16; i++) mem[i] = 8'h5A + 8'(i);

    assign mem_do = mem_e ? mem[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (mem_e && mem_we) begin
            mem[mem_addr] <= mem_di;
            wr_count      <= wr_count + 1;
            last_wa       <= mem_addr;
            last_wd       <= mem_di;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 0; i < 16; i++) begin
            #1;
            check({tag, "_addr"}, 32'(mem_addr), 32'(i));
            check({tag, "_we"}, 32'(mem_we && mem_e), 32'd1);
            check({tag, "_di"}, 32'(mem_di), 32'h00);
            check({tag, "_rdy"}, 32'(req_ready), 32'd0);
            check({tag, "_nc_e"}, 32'(mem_e2), 32'd0);
            @(negedge clk);
        end
        check({tag, "_done_rdy"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input string tag, input logic [1:0] op, input logic [3:0] a,
                          input logic [7:0] wd, input logic [7:0] exp, input int lat,
                          input int exp_writes, input int hold);
        int t;
        int n;
        int w0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        rsp_ready = (hold == 0);
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_accept"}, 32'(req_ready), 32'd1);
        w0 = wr_count;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp));
        check({tag, "_zero"}, 32'(rsp_zero), 32'(exp == 8'h00));
        check({tag, "_writes"}, 32'(wr_count - w0), 32'(exp_writes));
        for (int h = 0; h < hold; h++) begin
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(rsp_data), 32'(exp));
            check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
            check({tag, "_hold_e"}, 32'(mem_e), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'h00);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd1);
        check("rst_mem_e", 32'(mem_e), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_di", 32'(mem_di), 32'h00);

        rst       = 1'b0;
        req_valid = 1'b1;
        req_op    = OP_LOAD;
        req_addr  = 4'd5;
        #1;
        check("nc_ready_first", 32'(req_ready2), 32'd1);
        check("nc_busy_first", 32'(busy2), 32'd0);
        sweep_check("clr");
        req_valid = 1'b0;

        do_req("ld_clr", OP_LOAD, 4'd5, 8'h00, 8'h00, 2, 0, 0);
        do_req("st3", OP_STORE, 4'd3, 8'hA5, 8'hA5, 2, 1, 0);
        check("st3_waddr", 32'(last_wa), 32'd3);
        check("st3_wdata", 32'(last_wd), 32'hA5);
        do_req("ld3", OP_LOAD, 4'd3, 8'h00, 8'hA5, 2, 0, 0);
        do_req("st7", OP_STORE, 4'd7, 8'hFF, 8'hFF, 2, 1, 0);
        do_req("inc7", OP_INC, 4'd7, 8'h33, 8'h00, 3, 1, 0);
        check("inc7_wdata", 32'(last_wd), 32'h00);
        do_req("dec7", OP_DEC, 4'd7, 8'h00, 8'hFF, 3, 1, 0);
        check("dec7_wdata", 32'(last_wd), 32'hFF);
        do_req("dec_wrap_up", OP_DEC, 4'd7, 8'h00, 8'hFE, 3, 1, 0);
        do_req("ld3_hold", OP_LOAD, 4'd3, 8'h00, 8'hA5, 2, 0, 5);
        check("nc_still_idle", 32'(mem_e2), 32'd0);

        do_req("st9", OP_STORE, 4'd9, 8'h41, 8'h41, 2, 1, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_INC;
        req_addr  = 4'd9;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstinc_read_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("rstinc_write_we", 32'(mem_we), 32'd1);
        check("rstinc_write_di", 32'(mem_di), 32'h42);
        rst = 1'b1;
        #1;
        check("rstinc_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstinc_busy", 32'(busy), 32'd1);
        check("rstinc_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sweep_check("reclr");
        do_req("ld9_after", OP_LOAD, 4'd9, 8'h00, 8'h00, 2, 0, 0);
        do_req("ld3_after", OP_LOAD, 4'd3, 8'h00, 8'h00, 2, 0, 0);
        do_req("ld7_after", OP_LOAD, 4'd7, 8'h00, 8'h00, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
